sma_window_controller: RTL and testbench



---
 rtl/sma_pkg.sv | 14 +
 rtl/sma_window_controller.sv | 138 +++++++++++++
 tb/tb_sma_window_controller.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sma_pkg.sv
// Shared definitions for the SMA window controller and the price buffer memory beside it.
package sma_pkg;

  localparam int DEFAULT_NUM_STOCKS  = 4;
  localparam int DEFAULT_BUFFER_SIZE = 64;
  localparam int DEFAULT_DATA_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CAPTURE
  } sma_state_t;

endpackage

// File: rtl/sma_window_controller.sv
// Per-stock sliding-window controller: writes each price into its stock's circular
// slot in the external buffer memory, takes back the evicted price one cycle later,
// and keeps a running window sum, mean and window-full flag per stock.
module sma_window_controller
  import sma_pkg::*;
#(
  parameter int  NUM_STOCKS  = DEFAULT_NUM_STOCKS,
  parameter int  BUFFER_SIZE = DEFAULT_BUFFER_SIZE,
  parameter int  DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  localparam int ADDR_WIDTH  = $clog2(BUFFER_SIZE * NUM_STOCKS),
  localparam int STOCK_WIDTH = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
  localparam int PTR_WIDTH   = $clog2(BUFFER_SIZE),
  localparam int SUM_WIDTH   = DATA_WIDTH + PTR_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [STOCK_WIDTH-1:0] i_stock_id,
  input  logic [DATA_WIDTH-1:0]  i_price,
  output logic                   o_mem_write_en,
  output logic [ADDR_WIDTH-1:0]  o_mem_write_addr,
  output logic [DATA_WIDTH-1:0]  o_mem_write_data,
  input  logic [DATA_WIDTH-1:0]  i_mem_outgoing_price,
  output logic                   o_valid,
  output logic [STOCK_WIDTH-1:0] o_stock_id,
  output logic [SUM_WIDTH-1:0]   o_sum,
  output logic [DATA_WIDTH-1:0]  o_mean,
  output logic                   o_window_full
);

  localparam logic [PTR_WIDTH:0] FILL_MAX = (PTR_WIDTH + 1)'(BUFFER_SIZE);

  sma_state_t             state_q;
  logic [STOCK_WIDTH-1:0] stockId_q;
  logic [DATA_WIDTH-1:0]  price_q;

  logic [PTR_WIDTH-1:0]   ptr_q  [NUM_STOCKS];
  logic [PTR_WIDTH:0]     fill_q [NUM_STOCKS];
  logic [SUM_WIDTH-1:0]   sum_q  [NUM_STOCKS];

  logic                   ready_q;
  logic                   writeEn_q;
  logic [ADDR_WIDTH-1:0]  writeAddr_q;
  logic [DATA_WIDTH-1:0]  writeData_q;
  logic                   valid_q;
  logic [STOCK_WIDTH-1:0] outStockId_q;
  logic [SUM_WIDTH-1:0]   outSum_q;
  logic [DATA_WIDTH-1:0]  outMean_q;
  logic                   windowFull_q;

  logic                             idValid;
  logic [STOCK_WIDTH+PTR_WIDTH-1:0] addrFull;
  logic [DATA_WIDTH-1:0]            evicted;
  logic [PTR_WIDTH-1:0]             ptr_d;
  logic [PTR_WIDTH:0]               fill_d;
  logic [SUM_WIDTH-1:0]             sum_d;

  // Slot address for an incoming update and next window state for the latched stock;
  // memory contents only count as evicted once the stock's window has wrapped.
  always_comb begin
    idValid  = int'(i_stock_id) < NUM_STOCKS;
    addrFull = {i_stock_id, ptr_q[i_stock_id]};
    evicted  = (fill_q[stockId_q] == FILL_MAX) ? i_mem_outgoing_price : '0;
    sum_d    = sum_q[stockId_q] - SUM_WIDTH'(evicted) + SUM_WIDTH'(price_q);
    ptr_d    = ptr_q[stockId_q] + 1'b1;
    fill_d   = (fill_q[stockId_q] == FILL_MAX) ? FILL_MAX : fill_q[stockId_q] + 1'b1;
  end

  // Accept / write / capture sequencer holding the per-stock windows and all registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      stockId_q    <= '0;
      price_q      <= '0;
      ready_q      <= 1'b1;
      writeEn_q    <= 1'b0;
      writeAddr_q  <= '0;
      writeData_q  <= '0;
      valid_q      <= 1'b0;
      outStockId_q <= '0;
      outSum_q     <= '0;
      outMean_q    <= '0;
      windowFull_q <= 1'b0;
      for (int s = 0; s < NUM_STOCKS; s++) begin
        ptr_q[s]  <= '0;
        fill_q[s] <= '0;
        sum_q[s]  <= '0;
      end
    end else begin
      writeEn_q <= 1'b0;
      valid_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_valid && ready_q && idValid) begin
            stockId_q   <= i_stock_id;
            price_q     <= i_price;
            writeEn_q   <= 1'b1;
            writeAddr_q <= addrFull[ADDR_WIDTH-1:0];
            writeData_q <= i_price;
            ready_q     <= 1'b0;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          sum_q[stockId_q]  <= sum_d;
          ptr_q[stockId_q]  <= ptr_d;
          fill_q[stockId_q] <= fill_d;
          outStockId_q      <= stockId_q;
          outSum_q          <= sum_d;
          outMean_q         <= DATA_WIDTH'(sum_d >> PTR_WIDTH);
          windowFull_q      <= (fill_d == FILL_MAX);
          valid_q           <= 1'b1;
          ready_q           <= 1'b1;
          state_q           <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready          = ready_q;
  assign o_mem_write_en   = writeEn_q;
  assign o_mem_write_addr = writeAddr_q;
  assign o_mem_write_data = writeData_q;
  assign o_valid          = valid_q;
  assign o_stock_id       = outStockId_q;
  assign o_sum            = outSum_q;
  assign o_mean           = outMean_q;
  assign o_window_full    = windowFull_q;

endmodule

// File: tb/tb_sma_window_controller.sv
// Bench for sma_window_controller: two instances (2 stocks and 3 stocks, depth 4), each
// with a behavioural buffer memory, checked against a queue-based window model.
module tb_sma_window_controller;

  localparam int BS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: 2 stocks
  logic        aValid, aReady, aWe, aOValid, aFull;
  logic [0:0]  aId, aOId;
  logic [31:0] aPrice, aData, aOut, aMean;
  logic [2:0]  aAddr;
  logic [33:0] aSum;

  // Instance B: 3 stocks, so stock ID 3 is out of range
  logic        bValid, bReady, bWe, bOValid, bFull;
  logic [1:0]  bId, bOId;
  logic [31:0] bPrice, bData, bOut, bMean;
  logic [3:0]  bAddr;
  logic [33:0] bSum;

  sma_window_controller #(.NUM_STOCKS(2), .BUFFER_SIZE(BS), .DATA_WIDTH(32)) dutA (
    .i_clk(clk), .i_rst(rst), .i_valid(aValid), .o_ready(aReady),
    .i_stock_id(aId), .i_price(aPrice),
    .o_mem_write_en(aWe), .o_mem_write_addr(aAddr), .o_mem_write_data(aData),
    .i_mem_outgoing_price(aOut),
    .o_valid(aOValid), .o_stock_id(aOId), .o_sum(aSum), .o_mean(aMean),
    .o_window_full(aFull)
  );

  sma_window_controller #(.NUM_STOCKS(3), .BUFFER_SIZE(BS), .DATA_WIDTH(32)) dutB (
    .i_clk(clk), .i_rst(rst), .i_valid(bValid), .o_ready(bReady),
    .i_stock_id(bId), .i_price(bPrice),
    .o_mem_write_en(bWe), .o_mem_write_addr(bAddr), .o_mem_write_data(bData),
    .i_mem_outgoing_price(bOut),
    .o_valid(bOValid), .o_stock_id(bOId), .o_sum(bSum), .o_mean(bMean),
    .o_window_full(bFull)
  );

  // Buffer memories: on a write, the old slot content is registered as the outgoing price.
  logic [31:0] memA [8];
  logic [31:0] memB [16];
  always @(posedge clk) begin
    if (aWe) begin
      aOut        <= memA[aAddr];
      memA[aAddr] <= aData;
    end
    if (bWe) begin
      bOut        <= memB[bAddr];
      memB[bAddr] <= bData;
    end
  end

  // Everything observed about one transaction on instance A.
  typedef struct packed {
    logic        timedOut;
    logic [3:0]  weCount;
    logic [3:0]  validCount;
    logic [3:0]  readyLow;
    logic [3:0]  validCycle;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [7:0]  sid;
    logic [33:0] sum;
    logic [31:0] mean;
    logic        full;
  } obs_t;

  // Reference model: the last BS prices per stock and the number of writes so far.
  logic [31:0] histA [2][$];
  int          wrCnt [2];

  function automatic void clearModel();
    for (int s = 0; s < 2; s++) begin
      histA[s].delete();
      wrCnt[s] = 0;
    end
  endfunction

  function automatic obs_t modelA(input int id, input logic [31:0] price);
    obs_t e;
    logic [33:0] s;
    e = '0;
    s = '0;
    e.addr = 8'(id * BS + (wrCnt[id] % BS));
    wrCnt[id]++;
    histA[id].push_back(price);
    if (histA[id].size() > BS) void'(histA[id].pop_front());
    for (int k = 0; k < histA[id].size(); k++) s += 34'(histA[id][k]);
    e.weCount    = 4'd1;
    e.validCount = 4'd1;
    e.readyLow   = 4'd2;
    e.validCycle = 4'd3;
    e.data       = price;
    e.sid        = 8'(id);
    e.sum        = s;
    e.mean       = 32'(s / BS);
    e.full       = (histA[id].size() == BS);
    return e;
  endfunction

  task automatic resetDut();
    rst    = 1'b1;
    aValid = 1'b0;
    bValid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clearModel();
  endtask

  // Runs one update on instance A starting at a falling edge and records four cycles of outputs.
  task automatic driveA(input logic [0:0] id, input logic [31:0] price, output obs_t obs);
    int waitCyc;
    waitCyc = 0;
    obs = '0;
    while (aReady !== 1'b1 && waitCyc < 20) begin
      @(negedge clk);
      waitCyc++;
    end
    if (aReady !== 1'b1) begin
      obs.timedOut = 1'b1;
      return;
    end
    aValid = 1'b1;
    aId    = id;
    aPrice = price;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) aValid = 1'b0;
      if (aReady === 1'b0) obs.readyLow = obs.readyLow + 4'd1;
      if (aWe === 1'b1) begin
        obs.weCount = obs.weCount + 4'd1;
        obs.addr    = 8'(aAddr);
        obs.data    = aData;
      end
      if (aOValid === 1'b1) begin
        obs.validCount = obs.validCount + 4'd1;
        obs.validCycle = 4'(c);
        obs.sid        = 8'(aOId);
        obs.sum        = aSum;
        obs.mean       = aMean;
        obs.full       = aFull;
      end
    end
  endtask

  task automatic test_reset();
    resetDut();
    checks++;
    if ({aReady, bReady} !== 2'b11) begin
      failures++;
      $display("FAIL reset_ready actual=%b required=11", {aReady, bReady});
    end
    checks++;
    if ({aWe, aOValid, aFull, bWe, bOValid, bFull} !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes actual=%b required=000000", {aWe, aOValid, aFull, bWe, bOValid, bFull});
    end
    checks++;
    if ({aAddr, aData, aOId, aSum, aMean} !== '0) begin
      failures++;
      $display("FAIL reset_data actual=%h required=0", {aAddr, aData, aOId, aSum, aMean});
    end
  endtask

  task automatic test_first_price();
    obs_t obs, exp;
    resetDut();
    driveA(1'b0, 32'd100, obs);
    exp = modelA(0, 32'd100);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL first_price actual=%h required=%h", obs, exp);
    end
    checks++;
    if ({obs.addr, obs.sum, obs.mean, obs.full} !== {8'd0, 34'd100, 32'd25, 1'b0}) begin
      failures++;
      $display("FAIL first_price_values addr=%0d sum=%0d mean=%0d full=%b required 0/100/25/0",
               obs.addr, obs.sum, obs.mean, obs.full);
    end
  endtask

  task automatic test_fill_and_wrap();
    obs_t obs, exp;
    logic [31:0] prices [5];
    prices = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50};
    resetDut();
    for (int i = 0; i < 5; i++) begin
      driveA(1'b1, prices[i], obs);
      exp = modelA(1, prices[i]);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL fill_wrap_%0d actual=%h required=%h", i, obs, exp);
      end
      if (i == 3) begin
        checks++;
        if ({obs.addr, obs.sum, obs.mean, obs.full} !== {8'd7, 34'd100, 32'd25, 1'b1}) begin
          failures++;
          $display("FAIL fill_full addr=%0d sum=%0d mean=%0d full=%b required 7/100/25/1",
                   obs.addr, obs.sum, obs.mean, obs.full);
        end
      end
      if (i == 4) begin
        checks++;
        if ({obs.addr, obs.sum, obs.mean, obs.full} !== {8'd4, 34'd140, 32'd35, 1'b1}) begin
          failures++;
          $display("FAIL wrap_evict addr=%0d sum=%0d mean=%0d full=%b required 4/140/35/1",
                   obs.addr, obs.sum, obs.mean, obs.full);
        end
      end
    end
  endtask

  task automatic test_interleave();
    obs_t obs, exp;
    logic [0:0]  ids  [3];
    logic [31:0] prc  [3];
    logic [7:0]  adrs [3];
    logic [33:0] sums [3];
    ids  = '{1'b0, 1'b1, 1'b0};
    prc  = '{32'd5, 32'd7, 32'd5};
    adrs = '{8'd0, 8'd4, 8'd1};
    sums = '{34'd5, 34'd7, 34'd10};
    resetDut();
    for (int i = 0; i < 3; i++) begin
      driveA(ids[i], prc[i], obs);
      exp = modelA(int'(ids[i]), prc[i]);
      checks++;
      if (obs !== exp || obs.addr !== adrs[i] || obs.sum !== sums[i]) begin
        failures++;
        $display("FAIL interleave_%0d actual=%h required=%h (addr %0d sum %0d)",
                 i, obs, exp, adrs[i], sums[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prices [3];
    logic [33:0] expSums [$];
    obs_t exp;
    int acceptCyc [3];
    int k, writes, valids;
    logic sampledReady;
    prices = '{32'd11, 32'd22, 32'd33};
    k = 0;
    writes = 0;
    valids = 0;
    resetDut();
    aValid = 1'b1;
    aId    = 1'b1;
    aPrice = prices[0];
    for (int cyc = 0; cyc < 14; cyc++) begin
      sampledReady = aReady;
      @(posedge clk);
      if (sampledReady && aValid) begin
        acceptCyc[k] = cyc;
        exp = modelA(1, aPrice);
        expSums.push_back(exp.sum);
        k++;
      end
      @(negedge clk);
      if (aWe === 1'b1) writes++;
      if (aOValid === 1'b1) begin
        valids++;
        checks++;
        if (expSums.size() == 0 || aSum !== expSums[0]) begin
          failures++;
          $display("FAIL b2b_sum actual=%0d required=%0d", aSum,
                   (expSums.size() == 0) ? 34'd0 : expSums[0]);
        end
        if (expSums.size() != 0) void'(expSums.pop_front());
      end
      if (k == 3) aValid = 1'b0;
      else aPrice = prices[k];
    end
    aValid = 1'b0;
    checks++;
    if (writes != 3 || valids != 3 || k != 3) begin
      failures++;
      $display("FAIL b2b_counts writes=%0d valids=%0d accepts=%0d required 3/3/3", writes, valids, k);
    end
    checks++;
    if (k == 3 && (acceptCyc[1] - acceptCyc[0] != 3 || acceptCyc[2] - acceptCyc[1] != 3)) begin
      failures++;
      $display("FAIL b2b_spacing gaps=%0d,%0d required 3,3",
               acceptCyc[1] - acceptCyc[0], acceptCyc[2] - acceptCyc[1]);
    end
  endtask

  task automatic test_reset_mid_write();
    obs_t obs, exp;
    resetDut();
    aValid = 1'b1;
    aId    = 1'b0;
    aPrice = 32'd77;
    @(negedge clk);
    aValid = 1'b0;
    checks++;
    if (aWe !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre_we actual=%b required=1", aWe);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({aWe, aReady, aOValid} !== 3'b010) begin
      failures++;
      $display("FAIL midreset_drop actual we/ready/valid=%b required=010", {aWe, aReady, aOValid});
    end
    @(negedge clk);
    rst = 1'b0;
    clearModel();
    @(negedge clk);
    driveA(1'b0, 32'd8, obs);
    exp = modelA(0, 32'd8);
    checks++;
    if (obs !== exp || obs.addr !== 8'd0 || obs.sum !== 34'd8) begin
      failures++;
      $display("FAIL midreset_after actual=%h required=%h", obs, exp);
    end
  endtask

  task automatic test_invalid_id();
    int weCnt, vCnt, notReady;
    logic [3:0]  seenAddr;
    logic [31:0] seenData, seenMean;
    logic [33:0] seenSum;
    logic [1:0]  seenSid;
    resetDut();
    weCnt = 0; vCnt = 0; notReady = 0;
    bValid = 1'b1;
    bId    = 2'd3;
    bPrice = 32'd123;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bValid = 1'b0;
      if (bWe === 1'b1) weCnt++;
      if (bOValid === 1'b1) vCnt++;
      if (bReady !== 1'b1) notReady++;
    end
    checks++;
    if (weCnt != 0 || vCnt != 0 || notReady != 0) begin
      failures++;
      $display("FAIL invalid_id writes=%0d valids=%0d notready=%0d required 0/0/0", weCnt, vCnt, notReady);
    end
    weCnt = 0; vCnt = 0;
    seenAddr = '0; seenData = '0; seenSum = '0; seenMean = '0; seenSid = '0;
    bValid = 1'b1;
    bId    = 2'd2;
    bPrice = 32'd9;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bValid = 1'b0;
      if (bWe === 1'b1) begin
        weCnt++;
        seenAddr = bAddr;
        seenData = bData;
      end
      if (bOValid === 1'b1) begin
        vCnt++;
        seenSum  = bSum;
        seenMean = bMean;
        seenSid  = bOId;
      end
    end
    checks++;
    if (weCnt != 1 || vCnt != 1 ||
        {seenAddr, seenData, seenSum, seenMean, seenSid} !== {4'd8, 32'd9, 34'd9, 32'd2, 2'd2}) begin
      failures++;
      $display("FAIL stock2_after_invalid writes=%0d valids=%0d addr=%0d data=%0d sum=%0d mean=%0d sid=%0d required 1/1/8/9/9/2/2",
               weCnt, vCnt, seenAddr, seenData, seenSum, seenMean, seenSid);
    end
  endtask

  task automatic test_random();
    obs_t obs, exp;
    logic [0:0]  id;
    logic [31:0] price;
    resetDut();
    for (int i = 0; i < 40; i++) begin
      id    = 1'($urandom_range(0, 1));
      price = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1000));
      driveA(id, price, obs);
      exp = modelA(int'(id), price);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL random_%0d actual=%h required=%h", i, obs, exp);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    rst    = 1'b1;
    aValid = 1'b0;
    aId    = '0;
    aPrice = '0;
    bValid = 1'b0;
    bId    = '0;
    bPrice = '0;
    clearModel();
    @(negedge clk);
    test_reset();
    test_first_price();
    test_fill_and_wrap();
    test_interleave();
    test_back_to_back();
    test_reset_mid_write();
    test_invalid_id();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
